imem_loader: RTL and testbench
==============================

# imem_loader

Sequences the single-port instruction memory between the CPU fetch path and a byte-stream program loader. In normal running it passes the CPU's `pc` to the memory and returns the combinational read data as the fetched instruction. On a load request it stalls the CPU and receives a length-prefixed, checksummed byte stream. It assembles the bytes into instruction words and writes them to consecutive addresses from 0. It then releases the CPU, or holds it halted if the checksum fails.

## Interface
Parameters:
- `PC_WIDTH`, 8: instruction address width; memory depth is 2**PC_WIDTH.
- `INSTRUCTION_WIDTH`, 16: word width; must be a multiple of 8.
- `NOP`, 0: instruction presented to the CPU while stalled.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `load_start`  in  1  single-cycle load request.
- `rx_data`  in  8  loader byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  byte accepted when `rx_valid & rx_ready`.
- `cpu_pc`  in  PC_WIDTH  fetch address.
- `cpu_instruction`  out  INSTRUCTION_WIDTH  fetched word.
- `cpu_stall`  out  1  CPU must hold its pc.
- `mem_addr`  out  PC_WIDTH  memory address.
- `mem_we`  out  1  memory write enable.
- `mem_wdata`  out  INSTRUCTION_WIDTH  memory write data.
- `mem_rdata`  in  INSTRUCTION_WIDTH  memory combinational read data.
- `load_done`  out  1  one-cycle pulse on successful load.
- `load_error`  out  1  sticky checksum or length error.

## Operation
The FSM has six states: RUN, LEN, DATA, WRITE, CHECK, HALT. Reset enters RUN.

- **RUN**
  - `mem_addr = cpu_pc`, `cpu_instruction = mem_rdata`, `cpu_stall = 0`, `rx_ready = 0`.
  - `load_start` → LEN: clear `load_error`, pointer, checksum and byte counter.
- **LEN**
  - `rx_ready = 1`. The accepted byte L gives a word count of L+1 (1..256).
  - If L+1 > 2**PC_WIDTH: set `load_error` → HALT. Otherwise → DATA.
- **DATA**
  - `rx_ready = 1`. Bytes are shifted in MSB first; BPW = INSTRUCTION_WIDTH/8 bytes make one word.
  - Each accepted byte is added to an 8-bit modular checksum.
  - On acceptance of the BPW-th byte → WRITE.
- **WRITE** (exactly one cycle)
  - `mem_we = 1`, `mem_addr = ptr`, `mem_wdata = assembled word`, `rx_ready = 0`.
  - If ptr == L → CHECK. Otherwise ptr+1 → DATA.
  - ptr never wraps; address L is the last one written.
- **CHECK**
  - `rx_ready = 1`. If the accepted byte equals the checksum → RUN with a `load_done` pulse.
  - On mismatch: set `load_error` → HALT. Memory keeps the words already written.
- **HALT**
  - `rx_ready = 0`, `cpu_stall = 1`. `load_start` → LEN.
- **In all states other than RUN**
  - `cpu_stall = 1`, `cpu_instruction = NOP`.
  - Outside WRITE, `mem_addr = ptr`.
- **Boundary conditions**
  - `load_start` is ignored in LEN, DATA, WRITE and CHECK; there is no abort.
  - `rx_valid` gaps are allowed at any byte; a byte offered while `rx_ready = 0` stays pending and is not lost.
  - Reset during any state: RUN, with all registers cleared. Partially written memory is not restored.

## Timing
- **Reset values**
  - `rx_ready = 0`, `mem_we = 0`, `cpu_stall = 0`, `load_done = 0`, `load_error = 0`, `mem_wdata = 0`.
  - `mem_addr = cpu_pc` and `cpu_instruction = mem_rdata` (pass-through).
- **RUN fetch**
  - Zero latency: `cpu_instruction` follows `cpu_pc` combinationally.
- **Stall and writes**
  - `load_start` sampled at edge t gives `cpu_stall = 1` from t+1.
  - The last byte of a word accepted at edge t gives `mem_we = 1` during the cycle after t.
- **Throughput**
  - BPW+1 cycles per word at full `rx_valid` rate; at most one write per WRITE cycle.
- **Completion**
  - Checksum byte accepted at edge t gives `load_done = 1` and `cpu_stall = 0` in the cycle after t.
  - `load_error` is registered and sticky until the next accepted `load_start`.
- **Output sourcing**
  - `cpu_stall`, `rx_ready` and `mem_we` decode from the state register only.

## Structure
- **Shared package `loader_pkg`**
  - State enum `loader_state_t`.
  - `BYTE_WIDTH = 8`.
  - Default `NOP`.
  - Function computing BPW.
- **Sub-module `word_assembler`**
  - Shift register plus byte counter.
  - Inputs: `shift_en`, `clear`. Outputs: `word`, `word_full`.
  - The FSM, pointer and checksum stay in `imem_loader`.

## Test plan
All scenarios use INSTRUCTION_WIDTH=16 and PC_WIDTH=8.

1. After reset, no load; drive `cpu_pc` = 3 with `mem_rdata` = 0x5A5A → `cpu_instruction` = 0x5A5A, `mem_addr` = 3, `cpu_stall` = 0, `rx_ready` = 0.
2. Good load: `load_start`, then bytes 01 12 34 AB CD BE → writes 0x1234@0 and 0xABCD@1, each one cycle after its second byte; one `load_done` pulse; `cpu_stall` = 0 the next cycle.
3. Bad checksum: same stream with final byte 00 → `load_error` = 1, `cpu_stall` stays 1, `rx_ready` = 0. A following `load_start` clears `load_error`.
4. Backpressure: 3-cycle `rx_valid` gaps between bytes, with a byte offered during WRITE → the byte is held until `rx_ready`, no byte is duplicated or lost, and the same memory contents as scenario 2 result.
5. Reset asserted mid-DATA after the write at address 0 → RUN immediately, `cpu_stall` = 0, no further `mem_we`; a `load_start` pulse during DATA in a separate run is ignored.
6. Length byte 0xFF followed by 512 data bytes → 256 writes to addresses 0..255 with no wrap and no write after 255; `load_done` follows a correct checksum.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state enum, byte width, default NOP and the bytes-per-word helper live here.
package loader_pkg;

  localparam int BYTE_WIDTH  = 8;
  localparam int DEFAULT_NOP = 0;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_HALT
  } loader_state_t;

  function automatic int bytes_per_word(input int word_width);
    return word_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into words, MSB first. The word register updates on the edge
// that accepts a byte. word_full flags the byte that completes a word; there is no backpressure.
module word_assembler
  import loader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [WIDTH-1:0]      word,
  output logic                  word_full
);

  localparam int BPW = bytes_per_word(WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0] count;

  // Asserted during the shift that completes the word, so the FSM can leave DATA on that edge.
  assign word_full = shift_en && (count == CW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift_en) begin
      word  <= (word << BYTE_WIDTH) | WIDTH'(byte_in);
      count <= word_full ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader. RUN fetch is combinational. A completed word is written the cycle after its last byte.
// rx_ready decodes from the state only, so a byte offered during WRITE, RUN or HALT is held by the sender.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                           PC_WIDTH          = 8,
  parameter int                           INSTRUCTION_WIDTH = 16,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP               = INSTRUCTION_WIDTH'(DEFAULT_NOP)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic [BYTE_WIDTH-1:0]        rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  input  logic [PC_WIDTH-1:0]          cpu_pc,
  output logic [INSTRUCTION_WIDTH-1:0] cpu_instruction,
  output logic                         cpu_stall,
  output logic [PC_WIDTH-1:0]          mem_addr,
  output logic                         mem_we,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic                         load_done,
  output logic                         load_error
);

  // Wide enough to hold both the word count L+1 and the memory depth 2**PC_WIDTH.
  localparam int LW = ((PC_WIDTH > BYTE_WIDTH) ? PC_WIDTH : BYTE_WIDTH) + 1;

  loader_state_t         state, next_state;
  logic [PC_WIDTH-1:0]   ptr;
  logic [BYTE_WIDTH-1:0] len;
  logic [BYTE_WIDTH-1:0] csum;
  logic                  accept, shift_en, clr, set_err, done_set;
  logic                  too_long, last_word, word_full;
  logic [INSTRUCTION_WIDTH-1:0] word;

  assign accept    = rx_valid && rx_ready;
  assign shift_en  = accept && (state == ST_DATA);
  assign too_long  = (LW'(rx_data) + LW'(1)) > (LW'(1) << PC_WIDTH);
  assign last_word = (LW'(ptr) == LW'(len));

  word_assembler #(.WIDTH(INSTRUCTION_WIDTH)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (clr),
    .byte_in   (rx_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    clr        = 1'b0;
    set_err    = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      ST_RUN, ST_HALT: begin
        if (load_start) begin
          next_state = ST_LEN;
          clr        = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (too_long) begin
            set_err    = 1'b1;
            next_state = ST_HALT;
          end else begin
            next_state = ST_DATA;
          end
        end
      end
      ST_DATA:  if (word_full) next_state = ST_WRITE;
      ST_WRITE: next_state = last_word ? ST_CHECK : ST_DATA;
      ST_CHECK: begin
        if (accept) begin
          if (rx_data == csum) begin
            done_set   = 1'b1;
            next_state = ST_RUN;
          end else begin
            set_err    = 1'b1;
            next_state = ST_HALT;
          end
        end
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    cpu_stall       = (state != ST_RUN);
    rx_ready        = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHECK);
    mem_we          = (state == ST_WRITE);
    mem_addr        = (state == ST_RUN) ? cpu_pc : ptr;
    mem_wdata       = word;
    cpu_instruction = (state == ST_RUN) ? mem_rdata : NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      len        <= '0;
      csum       <= '0;
      load_error <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= done_set;
      if (clr) begin
        ptr        <= '0;
        csum       <= '0;
        load_error <= 1'b0;
      end else begin
        if (set_err)                    load_error <= 1'b1;
        if (state == ST_LEN && accept)  len        <= rx_data;
        if (shift_en)                   csum       <= csum + rx_data;
        // The pointer stops at L, so the last word never wraps the address.
        if (state == ST_WRITE && !last_word) ptr <= ptr + PC_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a driver pushes expected writes, a negedge monitor pops and compares.
// The reference is a plain byte-list model: words are byte pairs, checksum is the byte sum mod 256.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  cpu_pc = 8'h00;
  logic [15:0] cpu_instruction;
  logic        cpu_stall;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        load_done;
  logic        load_error;

  imem_loader #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16), .NOP(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_start      (load_start),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .cpu_pc          (cpu_pc),
    .cpu_instruction (cpu_instruction),
    .cpu_stall       (cpu_stall),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] model [256];
  logic [7:0]  pay [512];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          done_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT performs must match the next expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", {24'h0, mem_addr}, {24'h0, mon_e.addr});
          check("write_data", {16'h0, mem_wdata}, {16'h0, mon_e.data});
        end
      end
      if (load_done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  function automatic int gap_for(input int mode, input bit word_start);
    if (mode == 0) return 0;
    if (mode == 1) return word_start ? 0 : 3;
    return int'($urandom_range(0, 3));
  endfunction

  // Offers one byte after `gap` idle cycles and returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: rx_ready low for %0d cycles, required 1", n);
        break;
      end
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Full load of len_b+1 words from pay[]; poke >= 0 pulses load_start before that data byte.
  task automatic run_load(input int len_b, input bit corrupt, input int mode, input int poke);
    int   sum;
    int   w;
    logic [7:0] cs;
    pulse_start();
    check("stall_after_start", {31'h0, cpu_stall}, 32'h1);
    check("nop_while_stalled", {16'h0, cpu_instruction}, 32'h0);
    check("error_cleared", {31'h0, load_error}, 32'h0);
    send_byte(8'(len_b), gap_for(mode, 1'b0));
    sum = 0;
    for (int b = 0; b < 2 * (len_b + 1); b++) begin
      if (b == poke) pulse_start();
      sum += int'(pay[b]);
      if (b % 2 == 1) begin
        w = b / 2;
        model[w] = {pay[b-1], pay[b]};
        exp_q.push_back('{addr: 8'(w), data: {pay[b-1], pay[b]}});
      end
      send_byte(pay[b], gap_for(mode, (b % 2) == 0));
      if (b % 2 == 1) begin
        check("we_cycle_after_word", {31'h0, mem_we}, 32'h1);
        check("addr_cycle_after_word", {24'h0, mem_addr}, 32'(w));
      end
    end
    cs = 8'(sum);
    if (corrupt) cs = cs + 8'($urandom_range(1, 255));
    send_byte(cs, gap_for(mode, 1'b1));
    if (!corrupt) begin
      done_exp++;
      check("done_pulse", {31'h0, load_done}, 32'h1);
      check("released", {31'h0, cpu_stall}, 32'h0);
      check("no_error", {31'h0, load_error}, 32'h0);
      tick();
      check("done_one_cycle", {31'h0, load_done}, 32'h0);
    end else begin
      check("error_set", {31'h0, load_error}, 32'h1);
      check("halt_stall", {31'h0, cpu_stall}, 32'h1);
      check("halt_rx_ready", {31'h0, rx_ready}, 32'h0);
      check("halt_no_done", {31'h0, load_done}, 32'h0);
      tick();
      check("error_sticky", {31'h0, load_error}, 32'h1);
      check("halt_nop", {16'h0, cpu_instruction}, 32'h0);
    end
  endtask

  task automatic fetch_check(input int a);
    cpu_pc = 8'(a);
    #1;
    check("fetch", {16'h0, cpu_instruction}, {16'h0, model[a]});
  endtask

  task automatic set_basic_stream();
    pay[0] = 8'h12; pay[1] = 8'h34; pay[2] = 8'hAB; pay[3] = 8'hCD;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) | 16'h0001;
    mem[3] = 16'h5A5A;
    tick();
    tick();
    rst_n = 1'b1;
    cpu_pc = 8'd3;
    tick();

    // Reset state and pass-through fetch
    check("rst_instruction", {16'h0, cpu_instruction}, 32'h5A5A);
    check("rst_mem_addr", {24'h0, mem_addr}, 32'h3);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_done", {31'h0, load_done}, 32'h0);
    check("rst_error", {31'h0, load_error}, 32'h0);
    check("rst_wdata", {16'h0, mem_wdata}, 32'h0);

    // Good load at full rate
    set_basic_stream();
    run_load(1, 1'b0, 0, -1);
    fetch_check(0);
    fetch_check(1);

    // Bad checksum, then recovery from HALT with gaps that put bytes on WRITE cycles
    run_load(1, 1'b1, 0, -1);
    for (int i = 0; i < 2; i++) model[i] = 16'h0000;
    run_load(1, 1'b0, 1, -1);
    fetch_check(0);
    fetch_check(1);

    // Reset in the middle of DATA after word 0 has been written
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    exp_q.push_back('{addr: 8'h00, data: 16'h1234});
    send_byte(8'h34, 0);
    send_byte(8'hAB, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'h0, cpu_stall}, 32'h0);
    check("midreset_rx_ready", {31'h0, rx_ready}, 32'h0);
    check("midreset_we", {31'h0, mem_we}, 32'h0);
    tick();
    rst_n = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hCD;
    repeat (5) tick();
    rx_valid = 1'b0;
    check("after_reset_run", {31'h0, cpu_stall}, 32'h0);

    // load_start during DATA must not restart the load
    set_basic_stream();
    run_load(1, 1'b0, 0, 1);

    // Largest load: 256 words, last address 255, no wrap
    for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
    run_load(255, 1'b0, 0, -1);
    fetch_check(0);
    fetch_check(255);
    for (int i = 0; i < 6; i++) fetch_check(int'($urandom_range(1, 254)));
    repeat (4) tick();

    // Random loads with random gaps and random checksum outcome
    for (int r = 0; r < 5; r++) begin
      int  l;
      bit  bad;
      l   = int'($urandom_range(0, 20));
      bad = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2 * (l + 1); i++) pay[i] = 8'($urandom);
      run_load(l, bad, 2, -1);
      if (!bad) fetch_check(int'($urandom_range(0, l)));
    end
    pulse_start();
    pay[0] = 8'h00; pay[1] = 8'h00;
    exp_q.push_back('{addr: 8'h00, data: 16'h0000});
    model[0] = 16'h0000;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    done_exp++;
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("done_count", 32'(done_seen), 32'(done_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running at 1 ms, required to finish earlier");
    $fatal(1, "timeout");
  end

endmodule
